// File: rtl/count_change_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count_pkg
// Description : Shared types for the count-change recorder: default counter
//               width, the tagged FIFO entry and the tracking FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package count_pkg;

    // Default width of the observed counter value
    localparam int CNT_W = 4;

    // One recorded change: wrap tag above the observed value
    typedef struct packed {
        logic             wrap;
        logic [CNT_W-1:0] value;
    } count_entry_t;

    // NO_BASE: no reference value yet; TRACK: prev holds the last seen value
    typedef enum logic [0:0] {
        NO_BASE = 1'b0,
        TRACK   = 1'b1
    } track_state_t;

endpackage : count_pkg
`default_nettype wire

// File: rtl/count_change_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : count_change_fifo_if
// Description : Valid/ready drain port carrying the head entry of the
//               count-change FIFO to its consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface count_change_fifo_if #(
    parameter int CNT_W = 4
);
    logic [CNT_W-1:0] out_data;
    logic             out_wrap;
    logic             out_valid;
    logic             out_ready;

    // Producer side: presents the head entry, observes ready
    modport master (
        output out_data,
        output out_wrap,
        output out_valid,
        input  out_ready
    );

    // Consumer side: observes the head entry, drives ready
    modport slave (
        input  out_data,
        input  out_wrap,
        input  out_valid,
        output out_ready
    );
endinterface : count_change_fifo_if
`default_nettype wire

// File: rtl/count_change_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered occupancy. A push into a
//               full FIFO is accepted only when a pop happens on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic [WIDTH-1:0]         wdata,
    output logic      [WIDTH-1:0]         rdata,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   level
);
    localparam int                  c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0]       c_FULL_LVL = DEPTH[c_AW:0];
    localparam logic [c_AW:0]       c_LVL_ONE  = {{c_AW{1'b0}}, 1'b1};
    localparam logic [c_AW-1:0]     c_PTR_ONE  = {{(c_AW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_level == c_FULL_LVL);
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign rdata     = r_mem[r_rd_ptr];
    // Pop is ignored when empty; a full FIFO takes a push only if a slot frees
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Storage write; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end
endmodule : sync_fifo
`default_nettype wire

// File: rtl/count_change_fifo.sv
`default_nettype none
// ============================================================================
// Module      : count_change_fifo
// Description : Watches an upstream counter, records each value change with a
//               wrap tag into a FIFO drained over a valid/ready port, and
//               flags entries lost to a full FIFO with a sticky overflow bit.
// Revision    : 1.0 - initial release
// ============================================================================
module count_change_fifo #(
    parameter int CNT_W = 4,
    parameter int DEPTH = 8
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire logic [CNT_W-1:0]       count_in,
    input  wire logic                   sample_en,
    count_change_fifo_if.master         out_if,
    output logic      [$clog2(DEPTH):0] level,
    output logic                        overflow,
    input  wire logic                   clear_ovf
);
    import count_pkg::*;

    // The entry struct is sized by the package width
    generate
        if (CNT_W != count_pkg::CNT_W) begin : g_width_check
            $error("count_change_fifo: CNT_W must match count_pkg::CNT_W");
        end
    endgenerate

    track_state_t     r_state;
    track_state_t     w_state_nxt;
    logic [CNT_W-1:0] r_prev;
    logic             w_prev_ld;
    logic             w_push;
    logic             w_pop;
    count_entry_t     w_entry;
    count_entry_t     w_head;
    logic             w_full;
    logic             w_empty;
    logic             r_overflow;

    // Tracking state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= NO_BASE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Change/wrap detection and next-state selection
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_prev_ld   = 1'b0;
        w_entry     = '0;
        case (r_state)
            NO_BASE: begin
                if (sample_en) begin
                    w_push        = 1'b1;
                    w_prev_ld     = 1'b1;
                    w_entry.wrap  = 1'b0;
                    w_entry.value = count_in;
                    w_state_nxt   = TRACK;
                end
            end
            TRACK: begin
                if (sample_en && (count_in != r_prev)) begin
                    w_push        = 1'b1;
                    w_prev_ld     = 1'b1;
                    w_entry.wrap  = (count_in < r_prev);
                    w_entry.value = count_in;
                end
            end
            default: begin
                w_state_nxt = NO_BASE;
            end
        endcase
    end

    // Last observed value; follows every change even if its entry is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= '0;
        end else if (w_prev_ld) begin
            r_prev <= count_in;
        end
    end

    assign w_pop = out_if.out_ready && !w_empty;

    sync_fifo #(
        .WIDTH (CNT_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_entry),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (level)
    );

    // Sticky overflow; a drop on the same edge as a clear keeps the flag set
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end else if (clear_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign overflow         = r_overflow;
    assign out_if.out_valid = !w_empty;
    assign out_if.out_data  = w_empty ? '0 : w_head.value;
    assign out_if.out_wrap  = w_empty ? 1'b0 : w_head.wrap;
endmodule : count_change_fifo
`default_nettype wire

// File: tb/tb_count_change_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_change_fifo
// Description : Directed self-checking bench for count_change_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_change_fifo;
    localparam int CNT_W = 4;
    localparam int DEPTH = 8;

    logic             clk;
    logic             reset;
    logic [CNT_W-1:0] count_in;
    logic             sample_en;
    logic [3:0]       level;
    logic             overflow;
    logic             clear_ovf;

    int checks;
    int errors;

    count_change_fifo_if #(.CNT_W(CNT_W)) u_if ();

    count_change_fifo #(
        .CNT_W (CNT_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .count_in  (count_in),
        .sample_en (sample_en),
        .out_if    (u_if),
        .level     (level),
        .overflow  (overflow),
        .clear_ovf (clear_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are checked on the falling edge
    task automatic do_reset();
        reset          = 1'b1;
        sample_en      = 1'b0;
        count_in       = '0;
        clear_ovf      = 1'b0;
        u_if.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Baseline 0 followed by 1..7 with no consumer: FIFO full with 0..7
    task automatic fill_to_full();
        u_if.out_ready = 1'b0;
        sample_en      = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            count_in = 4'(i);
            @(negedge clk);
        end
        sample_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", u_if.out_valid); end
        checks++; if (u_if.out_data !== 4'd0) begin errors++; $display("FAIL reset_data got %0d exp 0", u_if.out_data); end
        checks++; if (u_if.out_wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %0b exp 0", u_if.out_wrap); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", overflow); end
    endtask

    task automatic test_baseline_hold();
        do_reset();
        sample_en = 1'b1;
        count_in  = 4'd5;
        @(negedge clk);
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL base_level1 got %0d exp 1", level); end
        checks++; if (u_if.out_valid !== 1'b1 || u_if.out_data !== 4'd5 || u_if.out_wrap !== 1'b0) begin
            errors++; $display("FAIL base_head got v%0b d%0d w%0b exp v1 d5 w0", u_if.out_valid, u_if.out_data, u_if.out_wrap);
        end
        @(negedge clk);
        @(negedge clk);
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL base_held_level got %0d exp 1", level); end
        // Disabled sampling ignores a different value
        sample_en = 1'b0;
        count_in  = 4'd9;
        @(negedge clk);
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL en_low_level got %0d exp 1", level); end
        // Same value as prev after re-enabling: no new entry
        sample_en = 1'b1;
        count_in  = 4'd5;
        @(negedge clk);
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL same_val_level got %0d exp 1", level); end
        sample_en      = 1'b0;
        u_if.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (level !== 4'd0 || u_if.out_valid !== 1'b0 || u_if.out_data !== 4'd0) begin
            errors++; $display("FAIL base_drain got l%0d v%0b d%0d exp l0 v0 d0", level, u_if.out_valid, u_if.out_data);
        end
    endtask

    task automatic test_wrap_sequence();
        logic [3:0] vals [5];
        logic       wraps [5];
        vals  = '{4'd13, 4'd14, 4'd15, 4'd0, 4'd1};
        wraps = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        u_if.out_ready = 1'b1;
        sample_en      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            count_in = vals[i];
            @(negedge clk);
            checks++;
            if (u_if.out_valid !== 1'b1 || u_if.out_data !== vals[i] || u_if.out_wrap !== wraps[i] || level !== 4'd1) begin
                errors++;
                $display("FAIL seq_%0d got v%0b d%0d w%0b l%0d exp v1 d%0d w%0b l1", i, u_if.out_valid,
                         u_if.out_data, u_if.out_wrap, level, vals[i], wraps[i]);
            end
        end
        sample_en = 1'b0;
        @(negedge clk);
        checks++; if (u_if.out_valid !== 1'b0 || level !== 4'd0) begin
            errors++; $display("FAIL seq_empty got v%0b l%0d exp v0 l0", u_if.out_valid, level);
        end
    endtask

    task automatic test_overflow_drain();
        do_reset();
        fill_to_full();
        checks++; if (level !== 4'd8 || overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_full got l%0d o%0b exp l8 o0", level, overflow);
        end
        sample_en = 1'b1;
        count_in  = 4'd8;
        @(negedge clk);
        checks++; if (level !== 4'd8 || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_drop got l%0d o%0b exp l8 o1", level, overflow);
        end
        count_in = 4'd9;
        @(negedge clk);
        sample_en = 1'b0;
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        checks++; if (overflow !== 1'b0 || level !== 4'd8) begin
            errors++; $display("FAIL ovf_clear got o%0b l%0d exp o0 l8", overflow, level);
        end
        u_if.out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (u_if.out_valid !== 1'b1 || u_if.out_data !== 4'(i) || u_if.out_wrap !== 1'b0) begin
                errors++;
                $display("FAIL drain_%0d got v%0b d%0d w%0b exp v1 d%0d w0", i, u_if.out_valid,
                         u_if.out_data, u_if.out_wrap, i);
            end
            @(negedge clk);
        end
        checks++; if (level !== 4'd0 || u_if.out_valid !== 1'b0) begin
            errors++; $display("FAIL drain_end got l%0d v%0b exp l0 v0", level, u_if.out_valid);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        fill_to_full();
        sample_en      = 1'b1;
        count_in       = 4'd8;
        u_if.out_ready = 1'b1;
        @(negedge clk);
        sample_en      = 1'b0;
        u_if.out_ready = 1'b0;
        checks++; if (level !== 4'd8 || overflow !== 1'b0) begin
            errors++; $display("FAIL fullpp_level got l%0d o%0b exp l8 o0", level, overflow);
        end
        checks++; if (u_if.out_data !== 4'd1) begin
            errors++; $display("FAIL fullpp_head got %0d exp 1", u_if.out_data);
        end
        // Drain everything; the accepted value 8 must come out last
        u_if.out_ready = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            if (i == DEPTH) begin
                checks++; if (u_if.out_data !== 4'd8) begin
                    errors++; $display("FAIL fullpp_last got %0d exp 8", u_if.out_data);
                end
            end
            @(negedge clk);
        end
        u_if.out_ready = 1'b0;
    endtask

    task automatic test_clear_vs_set();
        do_reset();
        fill_to_full();
        sample_en = 1'b1;
        count_in  = 4'd12;
        clear_ovf = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        clear_ovf = 1'b0;
        checks++; if (overflow !== 1'b1) begin
            errors++; $display("FAIL clr_set_ovf got %0b exp 1", overflow);
        end
        checks++; if (u_if.out_data !== 4'd0 || level !== 4'd8) begin
            errors++; $display("FAIL clr_set_head got d%0d l%0d exp d0 l8", u_if.out_data, level);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        sample_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            count_in = 4'(10 + i);
            @(negedge clk);
        end
        sample_en = 1'b0;
        checks++; if (level !== 4'd4) begin
            errors++; $display("FAIL mid_level4 got %0d exp 4", level);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (level !== 4'd0 || u_if.out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_after_rst got l%0d v%0b exp l0 v0", level, u_if.out_valid);
        end
        sample_en = 1'b1;
        count_in  = 4'd7;
        @(negedge clk);
        sample_en = 1'b0;
        checks++; if (u_if.out_valid !== 1'b1 || u_if.out_data !== 4'd7 || u_if.out_wrap !== 1'b0 || level !== 4'd1) begin
            errors++; $display("FAIL mid_rebase got v%0b d%0d w%0b l%0d exp v1 d7 w0 l1", u_if.out_valid,
                               u_if.out_data, u_if.out_wrap, level);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_baseline_hold();
        test_wrap_sequence();
        test_overflow_drain();
        test_full_push_pop();
        test_clear_vs_set();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule : tb_count_change_fifo
`default_nettype wire

// File: doc/count_change_fifo.md
# count_change_fifo

Downstream consumer of the 4-bit up-counter's `count` output. Watches the counter value each clock and records every change as a tagged entry (value plus wrap flag) into a small FIFO. A valid/ready port drains the FIFO so a checker or scoreboard can read the count history at its own pace. A sticky overflow flag reports lost entries.

## Interface
Parameters:
- `CNT_W`, 4, width of the observed counter value
- `DEPTH`, 8, FIFO entries; power of two, ≥ 2

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `reset`  in  1  synchronous, active-high; one clock, `clk`
- `count_in`  in  CNT_W  counter value from the upstream counter
- `sample_en`  in  1  capture enable; when low, `count_in` is ignored and tracking state is held
- `out_data`  out  CNT_W  count value of the head entry
- `out_wrap`  out  1  head entry was produced by a wrap (new value < previous value)
- `out_valid`  out  1  head entry present
- `out_ready`  in  1  consumer accepts head when `out_valid & out_ready`
- `level`  out  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH
- `overflow`  out  1  sticky: at least one entry dropped because the FIFO was full
- `clear_ovf`  in  1  clears `overflow`

## Operation
- Tracking FSM, two states:
  - NO_BASE (reset state): on `sample_en`, load `prev <= count_in`, push entry {wrap=0, count_in}, go to TRACK.
  - TRACK: on `sample_en` and `count_in != prev`, push {wrap = (count_in < prev), count_in} and set `prev <= count_in`. Equal value: no push.
  - `sample_en` low: no push, no state/`prev` change.
- `prev` updates on every detected change, including dropped ones. Wrap is always relative to the last observed value.
- Push while full and no pop in the same cycle: entry dropped, `overflow <= 1`, `level` stays DEPTH.
- Push while full with a pop in the same cycle: accepted; `level` stays DEPTH, no overflow.
- Pop while empty is impossible, since `out_valid` is 0. There is no bypass: a push into an empty FIFO is not visible in the same cycle.
- `clear_ovf` and a new overflow in the same cycle: set wins, so `overflow` stays 1.
- Comparisons are unsigned, CNT_W bits. Pointers are $clog2(DEPTH) bits and wrap naturally.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_wrap`=0, `level`=0, `overflow`=0. FSM returns to NO_BASE; pointers go to 0.
- `out_data`/`out_wrap` are forced to 0 whenever `out_valid`=0.
- Latency: a change sampled at edge N produces `out_valid`=1 and the entry at the head after edge N, so it is visible in cycle N+1.
- `level` and `out_valid` are registered and reflect the pushes/pops of the previous edge.
- Reset mid-operation: all stored entries are discarded, and the first sample after reset is treated as a new baseline (wrap=0).
- Head data stays stable while `out_valid & !out_ready`.

## Structure
- Package `count_pkg`: `CNT_W` default constant, `count_entry_t` packed struct {wrap, value[CNT_W-1:0]}, FSM state enum `{NO_BASE, TRACK}`.
- Sub-module `sync_fifo` (parameterised on width/DEPTH; push/pop/full/empty/level, synchronous active-high reset).
- Top: FSM, `prev` register, change/wrap detect, overflow flag, output zero-gating.

## Test plan
- Reset, then `sample_en`=1 with `count_in`=5 held 3 cycles -> exactly one entry {0,5}; `level`=1 one cycle after the first edge.
- Count 13,14,15,0,1 with `out_ready`=1 -> outputs {0,13},{0,14},{0,15},{1,0},{0,1}, each one cycle after its sample.
- `out_ready`=0, 9 distinct increments after the baseline -> `level`=8, `overflow`=1; then `clear_ovf` -> 0; drain returns the first 8 values in order.
- Full FIFO plus a change with `out_ready`=1 in the same cycle -> push accepted, `level` stays 8, `overflow` stays 0.
- `clear_ovf`=1 in the same cycle as a dropped push -> `overflow` remains 1.
- `reset` asserted with `level`=4 -> next cycle `level`=0, `out_valid`=0; next sample of 7 gives {0,7}, not a wrap relative to the old `prev`.
